decifra_bloco_iterativa: RTL and testbench

Iterative AES-128 inverse cipher (FIPS-197 InvCipher) that recovers a 128-bit plaintext block from a ciphertext block and a 128-bit key, computing one round per clock. It is the receive-side counterpart of the team's AES-128 encryption path. It sits behind a valid/ready input port and drives a valid/ready output port. The expanded round keys are cached, so back-to-back blocks under the same key skip expansion.

---
 rtl/aes_pkg.sv | 104 ++++++++++
 rtl/rodada_inversa.sv | 39 +++
 rtl/decifra_bloco_iterativa.sv | 141 ++++++++++++++
 tb/tb_decifra_bloco_iterativa.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the iterative inverse cipher: S-boxes, Rcon,
// GF(2^8) helpers, key-expansion step and the controller state type.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [2:0] {
    IDLE,
    EXPANDE,
    INICIAL,
    RODADA,
    SAIDA
  } estado_t;

  // Forward S-box, byte b at bits [2047-8b -: 8]
  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // The inverse table is derived from the forward one so the two can never disagree
  function automatic logic [2047:0] gera_inv_sbox();
    logic [2047:0] t;
    logic [7:0]    s;
    t = '0;
    for (int i = 0; i < 256; i++) begin
      s = SBOX_TAB[{~8'(i), 3'b000} +: 8];
      t[{~s, 3'b000} +: 8] = 8'(i);
    end
    return t;
  endfunction

  localparam logic [2047:0] INV_SBOX_TAB = gera_inv_sbox();

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TAB[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TAB[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One AES-128 key-schedule step: rk[i] from rk[i-1]
  function automatic logic [127:0] expande_chave(input logic [127:0] prev, input logic [3:0] i);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({prev[23:0], prev[31:24]}) ^ {rcon(i), 24'h000000};
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64]  ^ n0;
    n2 = prev[63:32]  ^ n1;
    n3 = prev[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/rodada_inversa.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// unless this is the last round, InvMixColumns.
module rodada_inversa
  import aes_pkg::*;
(
  input  logic [127:0] estado_in,
  input  logic [127:0] rk,
  input  logic         ultima,
  output logic [127:0] estado_out
);

  logic [127:0] w_add;
  logic [127:0] w_mix;

  // Byte gi sits at row gi%4, column gi/4; row r is rotated right by r columns
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int LIN  = gi % 4;
    localparam int COL  = gi / 4;
    localparam int ORIG = LIN + 4 * ((COL - LIN + 4) % 4);
    assign w_add[127-8*gi -: 8] = inv_sbox(estado_in[127-8*ORIG -: 8]) ^ rk[127-8*gi -: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = w_add[127-32*gi -: 8];
    assign w_a1 = w_add[119-32*gi -: 8];
    assign w_a2 = w_add[111-32*gi -: 8];
    assign w_a3 = w_add[103-32*gi -: 8];
    assign w_mix[127-32*gi -: 32] = {
      gf_mul(w_a0, 8'h0e) ^ gf_mul(w_a1, 8'h0b) ^ gf_mul(w_a2, 8'h0d) ^ gf_mul(w_a3, 8'h09),
      gf_mul(w_a0, 8'h09) ^ gf_mul(w_a1, 8'h0e) ^ gf_mul(w_a2, 8'h0b) ^ gf_mul(w_a3, 8'h0d),
      gf_mul(w_a0, 8'h0d) ^ gf_mul(w_a1, 8'h09) ^ gf_mul(w_a2, 8'h0e) ^ gf_mul(w_a3, 8'h0b),
      gf_mul(w_a0, 8'h0b) ^ gf_mul(w_a1, 8'h0d) ^ gf_mul(w_a2, 8'h09) ^ gf_mul(w_a3, 8'h0e)
    };
  end

  assign estado_out = ultima ? w_add : w_mix;

endmodule

// File: rtl/decifra_bloco_iterativa.sv
// Iterative AES-128 decryptor, one round per clock, with a cached round-key
// bank so consecutive blocks under the same key skip the expansion phase.
module decifra_bloco_iterativa
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inicio,
  output logic         pronto_entrada,
  input  logic [127:0] bloco,
  input  logic [127:0] chave,
  output logic [127:0] saida,
  output logic         saida_valida,
  input  logic         saida_pronta
);

  estado_t      r_state;
  estado_t      w_state_next;
  logic [3:0]   r_cnt;
  logic         r_cache_ok;
  logic [127:0] r_key;
  logic [127:0] r_bloco;
  logic [127:0] r_estado;
  logic [127:0] r_prev;
  logic [127:0] r_saida;
  logic         r_valida;

  logic [127:0] r_rk [0:NR];

  logic         w_acerto;
  logic [127:0] w_rk_nova;
  logic [127:0] w_rk_rodada;
  logic [127:0] w_rk_final;
  logic [127:0] w_rodada_out;
  logic         w_ultima;
  logic         w_grava_rk;
  logic [3:0]   w_end_rk;
  logic [127:0] w_dado_rk;

  assign w_acerto     = r_cache_ok && (chave == r_key);
  assign w_rk_nova    = expande_chave(r_prev, r_cnt);
  assign w_rk_rodada  = r_rk[r_cnt];
  assign w_rk_final   = r_rk[NR];
  assign w_ultima     = (r_cnt == 4'd0);

  rodada_inversa u_rodada (
    .estado_in  (r_estado),
    .rk         (w_rk_rodada),
    .ultima     (w_ultima),
    .estado_out (w_rodada_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_grava_rk   = 1'b0;
    w_end_rk     = r_cnt;
    w_dado_rk    = w_rk_nova;
    case (r_state)
      IDLE: begin
        if (inicio) begin
          w_state_next = w_acerto ? INICIAL : EXPANDE;
          if (!w_acerto) begin
            w_grava_rk = 1'b1;
            w_end_rk   = 4'd0;
            w_dado_rk  = chave;
          end
        end
      end
      EXPANDE: begin
        w_grava_rk = 1'b1;
        if (r_cnt == 4'(NR)) w_state_next = INICIAL;
      end
      INICIAL: w_state_next = RODADA;
      RODADA:  if (w_ultima) w_state_next = SAIDA;
      SAIDA:   if (saida_pronta) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Key bank carries no reset: its contents only matter once r_cache_ok is set
  always_ff @(posedge clk) begin
    if (w_grava_rk) r_rk[w_end_rk] <= w_dado_rk;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_cache_ok <= 1'b0;
      r_key      <= '0;
      r_bloco    <= '0;
      r_estado   <= '0;
      r_prev     <= '0;
      r_saida    <= '0;
      r_valida   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (inicio) begin
            r_bloco <= bloco;
            if (!w_acerto) begin
              r_key      <= chave;
              r_prev     <= chave;
              r_cache_ok <= 1'b0;
              r_cnt      <= 4'd1;
            end
          end
        end
        EXPANDE: begin
          r_prev <= w_rk_nova;
          if (r_cnt == 4'(NR)) r_cache_ok <= 1'b1;
          else                 r_cnt      <= r_cnt + 4'd1;
        end
        INICIAL: begin
          r_estado <= r_bloco ^ w_rk_final;
          r_cnt    <= 4'(NR - 1);
        end
        RODADA: begin
          r_estado <= w_rodada_out;
          if (w_ultima) begin
            r_saida  <= w_rodada_out;
            r_valida <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        SAIDA: if (saida_pronta) r_valida <= 1'b0;
        default: ;
      endcase
    end
  end

  assign pronto_entrada = (r_state == IDLE);
  assign saida          = r_saida;
  assign saida_valida   = r_valida;

endmodule

// File: tb/tb_decifra_bloco_iterativa.sv
// Directed bench for decifra_bloco_iterativa using FIPS-197 vectors, cache
// hit/miss latencies, output back-pressure and asynchronous reset.
module tb_decifra_bloco_iterativa;

  logic         clk;
  logic         rst_n;
  logic         inicio;
  logic         pronto_entrada;
  logic [127:0] bloco;
  logic [127:0] chave;
  logic [127:0] saida;
  logic         saida_valida;
  logic         saida_pronta;

  int errors;
  int checks;
  int lat;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K3 = 128'h0;
  localparam logic [127:0] C3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] P3 = 128'h0;

  decifra_bloco_iterativa dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inicio         (inicio),
    .pronto_entrada (pronto_entrada),
    .bloco          (bloco),
    .chave          (chave),
    .saida          (saida),
    .saida_valida   (saida_valida),
    .saida_pronta   (saida_pronta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [127:0] k, input logic [127:0] b);
    int n;
    n = 0;
    while (!pronto_entrada && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chave  = k;
    bloco  = b;
    inicio = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0;
  endtask

  task automatic wait_valid(output int l);
    l = 0;
    while (!saida_valida && l < 60) begin
      @(posedge clk);
      #1;
      l++;
    end
    $display("transaction: latency=%0d saida=%h", l, saida);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst_n        = 1'b0;
    inicio       = 1'b0;
    bloco        = '0;
    chave        = '0;
    saida_pronta = 1'b1;

    #12;
    check("rst_saida", saida, 128'h0);
    check("rst_valida", 128'(saida_valida), 128'h0);
    check("rst_pronto", 128'(pronto_entrada), 128'h1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: FIPS-197 C.1, cold cache
    send(K1, C1);
    wait_valid(lat);
    check("t1_lat", 128'(lat), 128'd21);
    check("t1_saida", saida, P1);
    @(posedge clk);
    #1;
    check("t1_pulse", 128'(saida_valida), 128'h0);
    check("t1_idle", 128'(pronto_entrada), 128'h1);

    // 2: same key again, cache hit
    send(K1, C1);
    wait_valid(lat);
    check("t2_lat", 128'(lat), 128'd11);
    check("t2_saida", saida, P1);
    @(posedge clk);
    #1;

    // 3: FIPS-197 App. B, key change
    send(K2, C2);
    wait_valid(lat);
    check("t3_lat", 128'(lat), 128'd21);
    check("t3_saida", saida, P2);
    @(posedge clk);
    #1;
    check("t3_drop", 128'(saida_valida), 128'h0);
    check("t3_hold", saida, P2);

    // 4: zero key with output back-pressure and an ignored input pulse
    saida_pronta = 1'b0;
    send(K3, C3);
    wait_valid(lat);
    check("t4_lat", 128'(lat), 128'd21);
    for (int i = 0; i < 5; i++) begin
      check("t4_valida", 128'(saida_valida), 128'h1);
      check("t4_saida", saida, P3);
      check("t4_busy", 128'(pronto_entrada), 128'h0);
      chave  = K1;
      bloco  = C1;
      inicio = (i == 2);
      @(posedge clk);
      #1;
    end
    inicio       = 1'b0;
    saida_pronta = 1'b1;
    @(posedge clk);
    #1;
    check("t4_rel_valida", 128'(saida_valida), 128'h0);
    check("t4_rel_idle", 128'(pronto_entrada), 128'h1);
    @(posedge clk);
    #1;
    check("t4_ignored", 128'(pronto_entrada), 128'h1);

    // 5: reset during the 5th expansion cycle
    send(K1, C1);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valida", 128'(saida_valida), 128'h0);
    check("t5_rst_saida", saida, 128'h0);
    check("t5_rst_idle", 128'(pronto_entrada), 128'h1);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(K1, C1);
    wait_valid(lat);
    check("t5_lat", 128'(lat), 128'd21);
    check("t5_saida", saida, P1);
    @(posedge clk);
    #1;

    // 6: reset while holding a result in SAIDA, cache must be invalidated
    saida_pronta = 1'b0;
    send(K1, C1);
    wait_valid(lat);
    check("t6_hit_lat", 128'(lat), 128'd11);
    @(posedge clk);
    #1;
    check("t6_hold", 128'(saida_valida), 128'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valida", 128'(saida_valida), 128'h0);
    check("t6_rst_saida", saida, 128'h0);
    check("t6_rst_idle", 128'(pronto_entrada), 128'h1);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_post_idle", 128'(pronto_entrada), 128'h1);
    saida_pronta = 1'b1;
    send(K1, C1);
    wait_valid(lat);
    check("t6_miss_lat", 128'(lat), 128'd21);
    check("t6_saida", saida, P1);
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
